// File: rtl/mmu_arb_pkg.sv
// Shared definitions for the DDR write-port arbiter.
// Contents: FSM state encoding, CPU register offsets, AXI ID width and a
// saturating-increment helper used by the statistics counters.
// Optional feature macro: MMU_ARB_STAT_EN (grant/beat counters in the top).
package mmu_arb_pkg;

    localparam int ID_WTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [11:0] REG_STATUS   = 12'h000;  // {state, os_cnt}
    localparam logic [11:0] REG_ERR      = 12'h004;  // err_cnt
    localparam logic [11:0] REG_GNT_BASE = 12'h010;  // grant count of requester i at +4*i
    localparam logic [11:0] REG_BEAT     = 12'h020;  // W beat count

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mmu_rr_arb.sv
// Round-robin picker: combinational search for the first requester at or
// after the registered pointer, wrapping. The pointer moves to cur_idx+1
// (mod REQ_NUM) when advance pulses, i.e. when the granted burst finishes.
// Ports:
//   clk_sys, rst    clock, async active-high reset (pointer -> 0)
//   req             request vector
//   advance/cur_idx burst done for requester cur_idx
//   ptr             current round-robin pointer
//   gnt_idx/gnt_vld picked requester and "any request" flag
module mmu_rr_arb #(
    parameter int REQ_NUM = 2,
    localparam int IDX_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic [REQ_NUM-1:0] req,
    input  logic               advance,
    input  logic [IDX_W-1:0]   cur_idx,
    output logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= (cur_idx == IDX_W'(REQ_NUM - 1)) ? '0 : cur_idx + 1'b1;
    end

    // Walk the ring from farthest to nearest so the nearest requester
    // (smallest distance from ptr) is the last assignment and wins.
    logic [IDX_W-1:0] idx;
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % REQ_NUM);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmu_ddr_wr_arb.sv
// Shares one DDR AXI4 write port (AW/W/B) between REQ_NUM requesters.
// Whole bursts are granted round-robin; the grant is held until the wlast
// beat completes. AWID/WID carry the requester index and B responses are
// routed back by BID. At most MAX_OS AWs may be outstanding (no B yet).
// Ports:
//   clk_sys, rst        clock, async active-high reset
//   s_aw*/s_w*/s_b*     per-requester AXI write slave ports (packed per index)
//   m_aw*/m_w*/m_b*     master port to the DDR controller
//   cnt_reg_clr         clears the statistics counters
//   cpu_*               register bus; cpu_data_out_arb is registered
// Optional feature macro: MMU_ARB_STAT_EN adds per-requester grant counters
// (0x010+4*i) and a W beat counter (0x020); otherwise those read 0.
module mmu_ddr_wr_arb
    import mmu_arb_pkg::*;
#(
    parameter int          REQ_NUM    = 2,
    parameter int          MAX_OS     = 8,
    parameter int          A_WTH      = 24,
    parameter int          D_WTH      = 32,
    parameter logic [11:0] REG_ARB_ID = 12'd3
) (
    input  logic                      clk_sys,
    input  logic                      rst,
    input  logic [REQ_NUM-1:0][63:0]  s_awaddr,
    input  logic [REQ_NUM-1:0][7:0]   s_awlen,
    input  logic [REQ_NUM-1:0][2:0]   s_awsize,
    input  logic [REQ_NUM-1:0]        s_awvalid,
    output logic [REQ_NUM-1:0]        s_awready,
    input  logic [REQ_NUM-1:0][511:0] s_wdata,
    input  logic [REQ_NUM-1:0][63:0]  s_wstrb,
    input  logic [REQ_NUM-1:0]        s_wlast,
    input  logic [REQ_NUM-1:0]        s_wvalid,
    output logic [REQ_NUM-1:0]        s_wready,
    output logic [REQ_NUM-1:0][1:0]   s_bresp,
    output logic [REQ_NUM-1:0]        s_bvalid,
    input  logic [REQ_NUM-1:0]        s_bready,
    output logic [ID_WTH-1:0]         m_awid,
    output logic [63:0]               m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [ID_WTH-1:0]         m_wid,
    output logic [511:0]              m_wdata,
    output logic [63:0]               m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [ID_WTH-1:0]         m_bid,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic                      cnt_reg_clr,
    input  logic [A_WTH-1:0]          cpu_addr,
    input  logic [D_WTH-1:0]          cpu_data_in,
    input  logic                      cpu_rd,
    input  logic                      cpu_wr,
    output logic [D_WTH-1:0]          cpu_data_out_arb
);

    localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int OS_W  = $clog2(MAX_OS) + 1;

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] gnt, gnt_idx, rr_ptr;
    logic             gnt_vld, os_ok, grant;
    logic [OS_W-1:0]  os_cnt;
    logic [31:0]      err_cnt;
    logic             aw_hs, w_hs, wlast_hs;
    logic             bid_ok, b_hs, b_dec, b_err;
    logic [IDX_W-1:0] bidx;

    mmu_rr_arb #(.REQ_NUM(REQ_NUM)) u_rr (
        .clk_sys (clk_sys),
        .rst     (rst),
        .req     (s_awvalid),
        .advance (wlast_hs),
        .cur_idx (gnt),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign os_ok    = os_cnt < OS_W'(MAX_OS);
    assign grant    = (state == ST_IDLE) && gnt_vld && os_ok;
    assign aw_hs    = (state == ST_ADDR) && m_awready;
    assign w_hs     = (state == ST_DATA) && s_wvalid[gnt] && m_wready;
    assign wlast_hs = w_hs && s_wlast[gnt];

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
        end else begin
            state <= state_nxt;
            if (grant)
                gnt <= gnt_idx;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant)     state_nxt = ST_ADDR;
            ST_ADDR: if (m_awready) state_nxt = ST_DATA;
            ST_DATA: if (wlast_hs)  state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Only the granted requester ever sees a ready; master fields are zero
    // outside their phase so the port is quiet between bursts.
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        m_awvalid = 1'b0;
        m_awid    = '0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awsize  = '0;
        m_wid     = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        m_wvalid  = 1'b0;
        if (state == ST_ADDR) begin
            m_awvalid      = 1'b1;
            m_awid         = ID_WTH'(gnt);
            m_awaddr       = s_awaddr[gnt];
            m_awlen        = s_awlen[gnt];
            m_awsize       = s_awsize[gnt];
            s_awready[gnt] = m_awready;
        end
        if (state == ST_DATA) begin
            m_wid         = ID_WTH'(gnt);
            m_wdata       = s_wdata[gnt];
            m_wstrb       = s_wstrb[gnt];
            m_wlast       = s_wlast[gnt];
            m_wvalid      = s_wvalid[gnt];
            s_wready[gnt] = m_wready;
        end
    end

    // B routing. Unknown IDs are swallowed (ready forced high) so a stray
    // response cannot wedge the controller.
    assign bid_ok = m_bid < ID_WTH'(REQ_NUM);
    assign bidx   = m_bid[IDX_W-1:0];

    always_comb begin
        s_bvalid = '0;
        s_bresp  = '0;
        m_bready = 1'b0;
        if (m_bvalid) begin
            m_bready = 1'b1;
            if (bid_ok) begin
                s_bvalid[bidx] = 1'b1;
                s_bresp[bidx]  = m_bresp;
                m_bready       = s_bready[bidx];
            end
        end
    end

    assign b_hs  = m_bvalid && m_bready;
    assign b_err = b_hs && (!bid_ok || os_cnt == '0);
    assign b_dec = b_hs && !b_err;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            os_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            case ({aw_hs, b_dec})
                2'b10:   os_cnt <= os_cnt + 1'b1;
                2'b01:   os_cnt <= os_cnt - 1'b1;
                default: os_cnt <= os_cnt;
            endcase
            if (cnt_reg_clr)
                err_cnt <= '0;
            else if (b_err)
                err_cnt <= sat_inc(err_cnt);
        end
    end

`ifdef MMU_ARB_STAT_EN
    logic [REQ_NUM-1:0][31:0] gnt_cnt;
    logic [31:0]              beat_cnt;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            gnt_cnt  <= '0;
            beat_cnt <= '0;
        end else if (cnt_reg_clr) begin
            gnt_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            if (aw_hs)
                gnt_cnt[gnt] <= sat_inc(gnt_cnt[gnt]);
            if (w_hs)
                beat_cnt <= sat_inc(beat_cnt);
        end
    end
`endif

    logic        reg_hit;
    logic [31:0] rd_val;

    assign reg_hit = cpu_addr[A_WTH-1:12] == (A_WTH-12)'(REG_ARB_ID);

    always_comb begin
        rd_val = '0;
        case (cpu_addr[11:0])
            REG_STATUS: rd_val = 32'({state, os_cnt});
            REG_ERR:    rd_val = err_cnt;
            default:    rd_val = '0;
        endcase
`ifdef MMU_ARB_STAT_EN
        for (int i = 0; i < REQ_NUM; i++)
            if (cpu_addr[11:0] == REG_GNT_BASE + 12'(4 * i))
                rd_val = gnt_cnt[i];
        if (cpu_addr[11:0] == REG_BEAT)
            rd_val = beat_cnt;
`endif
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst)
            cpu_data_out_arb <= '0;
        else if (cpu_rd)
            cpu_data_out_arb <= reg_hit ? D_WTH'(rd_val) : '0;
    end

    // No writable registers; the pointer is internal to the picker.
    logic unused_sig;
    assign unused_sig = ^{cpu_wr, cpu_data_in, rr_ptr};

endmodule

// File: tb/tb_mmu_ddr_wr_arb.sv
module tb_mmu_ddr_wr_arb;

    localparam int RN = 2;

    logic              clk_sys, rst;
    logic [RN-1:0][63:0]  s_awaddr;
    logic [RN-1:0][7:0]   s_awlen;
    logic [RN-1:0][2:0]   s_awsize;
    logic [RN-1:0]        s_awvalid, s_awready;
    logic [RN-1:0][511:0] s_wdata;
    logic [RN-1:0][63:0]  s_wstrb;
    logic [RN-1:0]        s_wlast, s_wvalid, s_wready;
    logic [RN-1:0][1:0]   s_bresp;
    logic [RN-1:0]        s_bvalid, s_bready;
    logic [3:0]   m_awid, m_wid, m_bid;
    logic [63:0]  m_awaddr;
    logic [7:0]   m_awlen;
    logic [2:0]   m_awsize;
    logic         m_awvalid, m_awready;
    logic [511:0] m_wdata;
    logic [63:0]  m_wstrb;
    logic         m_wlast, m_wvalid, m_wready;
    logic [1:0]   m_bresp;
    logic         m_bvalid, m_bready;
    logic         cnt_reg_clr, cpu_rd, cpu_wr;
    logic [23:0]  cpu_addr;
    logic [31:0]  cpu_data_in, cpu_data_out_arb;

    mmu_ddr_wr_arb #(.REQ_NUM(RN), .MAX_OS(8)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .cnt_reg_clr(cnt_reg_clr), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_data_out_arb(cpu_data_out_arb)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Requester model: every burst is 4 beats (awlen=3). req_tot is written by
    // the test, aw_done/owed by the model only.
    int req_tot [RN];
    int aw_done [RN];
    int owed    [RN];
    logic [RN-1:0] awf, wf;

    for (genvar r = 0; r < RN; r++) begin : g_req
        assign s_awvalid[r] = req_tot[r] > aw_done[r];
        assign s_awaddr[r]  = 64'h1000 * (r + 1) + 64'(aw_done[r]) * 64'h100;
        assign s_awlen[r]   = 8'd3;
        assign s_awsize[r]  = 3'd6;
        assign s_wvalid[r]  = owed[r] > 0;
        assign s_wlast[r]   = (owed[r] % 4) == 1;
        assign s_wdata[r]   = {448'd0, 32'(r), 32'(owed[r])};
        assign s_wstrb[r]   = '1;
    end

    always @(posedge clk_sys) begin
        awf = s_awvalid & s_awready;
        wf  = s_wvalid & s_wready;
        #1;
        for (int r = 0; r < RN; r++) begin
            if (rst) begin
                aw_done[r] = req_tot[r];
                owed[r]    = 0;
            end else begin
                if (awf[r]) begin aw_done[r] = aw_done[r] + 1; owed[r] = owed[r] + 4; end
                if (wf[r])  owed[r] = owed[r] - 1;
            end
        end
    end

    // Master-side monitor.
    int cyc;
    int aw_id_q[$];
    int w_id_q[$];
    int w_last_q[$];
    int w_cyc_q[$];
    initial cyc = 0;
    always @(posedge clk_sys) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (m_awvalid && m_awready) aw_id_q.push_back(int'(m_awid));
            if (m_wvalid && m_wready) begin
                w_id_q.push_back(int'(m_wid));
                w_last_q.push_back(int'(m_wlast));
                w_cyc_q.push_back(cyc);
            end
        end
    end

    int n_chk, n_pass;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic rd_reg(input logic [11:0] id, input logic [11:0] off, output logic [31:0] d);
        cpu_addr = {id, off};
        cpu_rd   = 1'b1;
        tick();
        cpu_rd   = 1'b0;
        d        = cpu_data_out_arb;
    endtask

    task automatic wait_w(input int n, input string nm);
        int t;
        t = 0;
        while (w_id_q.size() < n && t < 300) begin tick(); t++; end
        chk({nm, "_w_done"}, 64'(w_id_q.size() >= n), 64'd1);
    endtask

    task automatic wait_aw(input int n, input string nm);
        int t;
        t = 0;
        while (aw_id_q.size() < n && t < 300) begin tick(); t++; end
        chk({nm, "_aw_done"}, 64'(aw_id_q.size() >= n), 64'd1);
    endtask

    typedef struct {
        logic       bv;
        logic [3:0] bid;
        logic [1:0] bresp;
        logic [1:0] sbr;
        logic [1:0] e_sbv;
        logic [3:0] e_sbresp;
        logic       e_mbr;
    } bvec_t;

    bvec_t bt [7];

    initial begin
        logic [31:0] d;
        int awb, wb, bad;
        int exp_aw [4];

        // B-steering vectors, applied starting with 2 outstanding AWs.
        bt[0] = '{1'b0, 4'd0, 2'd0, 2'b11, 2'b00, 4'h0, 1'b0};  // no valid
        bt[1] = '{1'b1, 4'd0, 2'd0, 2'b00, 2'b01, 4'h0, 1'b0};  // bid0, held off
        bt[2] = '{1'b1, 4'd1, 2'd2, 2'b10, 2'b10, 4'h8, 1'b1};  // bid1 accepted, os 2->1
        bt[3] = '{1'b1, 4'd0, 2'd1, 2'b01, 2'b01, 4'h1, 1'b1};  // bid0 accepted, os 1->0
        bt[4] = '{1'b1, 4'd3, 2'd0, 2'b00, 2'b00, 4'h0, 1'b1};  // bad id: err
        bt[5] = '{1'b1, 4'd1, 2'd3, 2'b10, 2'b10, 4'hC, 1'b1};  // os=0: err
        bt[6] = '{1'b1, 4'd2, 2'd0, 2'b11, 2'b00, 4'h0, 1'b1};  // bad id: err

        n_chk = 0; n_pass = 0;
        rst = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1;
        m_bvalid = 1'b0; m_bid = '0; m_bresp = '0; s_bready = '0;
        cnt_reg_clr = 1'b0; cpu_addr = '0; cpu_data_in = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        for (int r = 0; r < RN; r++) req_tot[r] = 0;

        // Reset state
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_m_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst_m_wvalid", 64'(m_wvalid), 64'd0);
        chk("rst_s_awready", 64'(s_awready), 64'd0);
        chk("rst_m_bready", 64'(m_bready), 64'd0);
        chk("rst_cpu_data", 64'(cpu_data_out_arb), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        rd_reg(12'd3, 12'h000, d);
        chk("rst_status", 64'(d), 64'd0);

        // Two simultaneous bursts, pointer at 0: 0 then 1, no interleaving
        awb = aw_id_q.size(); wb = w_id_q.size();
        req_tot[0] = req_tot[0] + 1;
        req_tot[1] = req_tot[1] + 1;
        @(negedge clk_sys);
        chk("t1_lat_cycle0", 64'(m_awvalid), 64'd0);
        tick();
        @(negedge clk_sys);
        chk("t1_awvalid", 64'(m_awvalid), 64'd1);
        chk("t1_awid", 64'(m_awid), 64'd0);
        chk("t1_awaddr", m_awaddr, 64'h1000);
        chk("t1_awlen", 64'(m_awlen), 64'd3);
        tick();
        wait_w(wb + 8, "t1");
        chk("t1_aw0_id", 64'(aw_id_q[awb]), 64'd0);
        chk("t1_aw1_id", 64'(aw_id_q[awb + 1]), 64'd1);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (w_id_q[wb + k] != (k < 4 ? 0 : 1)) bad++;
            if (w_last_q[wb + k] != ((k % 4) == 3 ? 1 : 0)) bad++;
            if ((k % 4) != 0 && w_cyc_q[wb + k] != w_cyc_q[wb + k - 1] + 1) bad++;
        end
        chk("t1_w_order_last_nobubble", 64'(bad), 64'd0);

        // B steering table (2 outstanding at start)
        for (int i = 0; i < 7; i++) begin
            m_bvalid = bt[i].bv; m_bid = bt[i].bid; m_bresp = bt[i].bresp; s_bready = bt[i].sbr;
            @(negedge clk_sys);
            chk($sformatf("b%0d_s_bvalid", i), 64'(s_bvalid), 64'(bt[i].e_sbv));
            chk($sformatf("b%0d_s_bresp", i), 64'(s_bresp), 64'(bt[i].e_sbresp));
            chk($sformatf("b%0d_m_bready", i), 64'(m_bready), 64'(bt[i].e_mbr));
            tick();
        end
        m_bvalid = 1'b0; s_bready = '0; m_bid = '0;
        rd_reg(12'd3, 12'h000, d);
        chk("b_status_os0", 64'(d), 64'd0);
        rd_reg(12'd3, 12'h004, d);
        chk("b_err_cnt", 64'(d), 64'd3);
        cnt_reg_clr = 1'b1;
        tick();
        cnt_reg_clr = 1'b0;
        rd_reg(12'd3, 12'h004, d);
        chk("clr_err_cnt", 64'(d), 64'd0);

        // Req1 continuously valid, req0 arrives mid-burst
        awb = aw_id_q.size(); wb = w_id_q.size();
        req_tot[1] = req_tot[1] + 3;
        wait_w(wb + 1, "t2_first");
        req_tot[0] = req_tot[0] + 1;
        wait_w(wb + 16, "t2");
        exp_aw = '{1, 0, 1, 1};
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2_aw%0d_id", k), 64'(aw_id_q[awb + k]), 64'(exp_aw[k]));
        bad = 0;
        for (int k = 0; k < 16; k++)
            if (w_id_q[wb + k] != exp_aw[k / 4]) bad++;
        chk("t2_w_no_interleave", 64'(bad), 64'd0);
        rd_reg(12'd3, 12'h000, d);
        chk("t2_status_os4", 64'(d), 64'd4);
        rd_reg(12'd4, 12'h000, d);
        chk("t2_other_block_id", 64'(d), 64'd0);
`ifndef MMU_ARB_STAT_EN
        rd_reg(12'd3, 12'h020, d);
        chk("t2_beat_reg_off", 64'(d), 64'd0);
`endif

        // Outstanding limit: 4 more fill to 8, the 5th waits for a B
        awb = aw_id_q.size(); wb = w_id_q.size();
        req_tot[0] = req_tot[0] + 5;
        wait_aw(awb + 4, "t3");
        repeat (12) tick();
        chk("t3_aw_blocked_cnt", 64'(aw_id_q.size()), 64'(awb + 4));
        chk("t3_awvalid_blocked", 64'(m_awvalid), 64'd0);
        rd_reg(12'd3, 12'h000, d);
        chk("t3_status_os8", 64'(d), 64'd8);
        m_bvalid = 1'b1; m_bid = 4'd0; s_bready = 2'b01;
        @(negedge clk_sys);
        chk("t3_b_s_bvalid", 64'(s_bvalid), 64'd1);
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        @(negedge clk_sys);
        chk("t3_unblock_c1", 64'(m_awvalid), 64'd0);
        tick();
        @(negedge clk_sys);
        chk("t3_unblock_c2", 64'(m_awvalid), 64'd1);
        tick();
        wait_w(wb + 20, "t3");
        m_bvalid = 1'b1; m_bid = 4'd0; s_bready = 2'b01;
        repeat (7) tick();
        m_bvalid = 1'b0; s_bready = '0;
        rd_reg(12'd3, 12'h000, d);
        chk("t3_status_os1", 64'(d), 64'd1);

        // AW handshake and B (bid=1) in the same cycle
        wb = w_id_q.size();
        m_awready = 1'b0;
        req_tot[0] = req_tot[0] + 1;
        tick();
        tick();
        m_awready = 1'b1; m_bvalid = 1'b1; m_bid = 4'd1; s_bready = 2'b10;
        @(negedge clk_sys);
        chk("t4_awvalid", 64'(m_awvalid), 64'd1);
        chk("t4_s_bvalid", 64'(s_bvalid), 64'd2);
        chk("t4_m_bready", 64'(m_bready), 64'd1);
        tick();
        m_bvalid = 1'b0; s_bready = '0; m_bid = '0;
        wait_w(wb + 4, "t4");
        rd_reg(12'd3, 12'h000, d);
        chk("t4_status_os1", 64'(d), 64'd1);
        rd_reg(12'd3, 12'h004, d);
        chk("t4_err_cnt", 64'(d), 64'd0);

        // Reset in the middle of a W burst
        wb = w_id_q.size();
        req_tot[1] = req_tot[1] + 1;
        wait_w(wb + 2, "t5_mid");
        rst = 1'b1;
        @(negedge clk_sys);
        chk("t5_m_wvalid", 64'(m_wvalid), 64'd0);
        chk("t5_s_wready", 64'(s_wready), 64'd0);
        chk("t5_m_awvalid", 64'(m_awvalid), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rd_reg(12'd3, 12'h000, d);
        chk("t5_status_after_rst", 64'(d), 64'd0);
        awb = aw_id_q.size(); wb = w_id_q.size();
        req_tot[0] = req_tot[0] + 1;
        wait_w(wb + 4, "t5_new");
        chk("t5_new_awid", 64'(aw_id_q[awb]), 64'd0);
        chk("t5_new_wlast", 64'(w_last_q[wb + 3]), 64'd1);
        rd_reg(12'd3, 12'h000, d);
        chk("t5_status_os1", 64'(d), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mmu_ddr_wr_arb.md
Name: mmu_ddr_wr_arb

Overview:
Shares one DDR AXI4 write port (AW/W/B) between REQ_NUM write requesters, for example the mmu_tx packet writer and a kernel result writer.
- Grants whole bursts round-robin.
- Holds the grant until the W beat with wlast completes.
- Tags AWID with the requester index and routes B responses back by BID.
- Limits outstanding writes to MAX_OS.
- Sits between the MMU write paths and one DDR controller port; status registers are readable on the CPU bus.

Parameters:
REQ_NUM, 2, number of requesters (2..4)
MAX_OS, 8, maximum outstanding AW (accepted, no B yet) on the master port; power of 2
A_WTH, 24, CPU address width
D_WTH, 32, CPU data width
REG_ARB_ID, 12'd3, register block ID compared against cpu_addr[A_WTH-1:12]

Ports:
clk_sys  in  1  clock
rst  in  1  asynchronous active-high reset
s_awaddr  in  64*REQ_NUM  per-requester write address
s_awlen  in  8*REQ_NUM  burst length-1
s_awsize  in  3*REQ_NUM  beat size
s_awvalid  in  REQ_NUM  AW valid
s_awready  out  REQ_NUM  AW ready
s_wdata  in  512*REQ_NUM  write data
s_wstrb  in  64*REQ_NUM  byte strobes
s_wlast  in  REQ_NUM  last beat
s_wvalid  in  REQ_NUM  W valid
s_wready  out  REQ_NUM  W ready
s_bresp  out  2*REQ_NUM  response
s_bvalid  out  REQ_NUM  B valid
s_bready  in  REQ_NUM  B ready
m_awid/m_awaddr/m_awlen/m_awsize  out  4/64/8/3  to DDR
m_awvalid out 1; m_awready in 1
m_wid/m_wdata/m_wstrb/m_wlast/m_wvalid  out  4/512/64/1/1; m_wready in 1
m_bid in 4; m_bresp in 2; m_bvalid in 1; m_bready out 1
cnt_reg_clr  in  1  clear statistics
cpu_addr in A_WTH; cpu_data_in in D_WTH; cpu_rd in 1; cpu_wr in 1
cpu_data_out_arb  out  D_WTH  registered read data

Behaviour:
- Reset: all *valid/*ready outputs 0; m_* data fields 0; grant pointer = 0; outstanding count = 0; state IDLE; cpu_data_out_arb = 0.

State machine IDLE -> ADDR -> DATA -> IDLE:
- IDLE: if any s_awvalid and os_cnt < MAX_OS, latch grant g.
  - g is the first requesting index at or after rr_ptr, wrapping.
  - Go to ADDR on the next cycle.
- ADDR: m_awvalid = 1, carrying s_aw*[g], with m_awid = g zero-extended.
  - s_awready[g] = m_awready.
  - On handshake: os_cnt increments and the state goes to DATA.
- DATA: m_w* = s_w*[g]; m_wid = g; s_wready[g] = m_wready.
  - Only the granted requester is ever readied.
  - On a handshake with wlast: rr_ptr = g+1 (mod REQ_NUM), return to IDLE.
- Grant latency: 1 cycle from s_awvalid to m_awvalid. There is no bubble between W beats.

B channel:
- m_bvalid is steered to s_bvalid[m_bid]; m_bready = s_bready[m_bid].
- The B handshake decrements os_cnt.
- An m_bid >= REQ_NUM is accepted (m_bready = 1), dropped, and counted in err_cnt.
- AW accept and B return in the same cycle leave os_cnt unchanged.
- os_cnt == MAX_OS: IDLE does not grant; a B return unblocks it on the following cycle.
- os_cnt never underflows: a B with os_cnt = 0 is counted in err_cnt.

Registers (offset from cpu_addr[11:0]; cpu_data_out_arb updates 1 cycle after cpu_rd):
- 0x000: {state, os_cnt}
- 0x004: err_cnt
- Counters saturate at all-ones and are cleared by cnt_reg_clr.

Optional Feature:
MMU_ARB_STAT_EN:
- Defined: per-requester grant counters (32-bit, saturating) at 0x010+4*i, plus a 32-bit beat counter at 0x020.
- Undefined: those addresses read 0 and the counters are not instantiated.

Decomposition:
- Package mmu_arb_pkg: state encoding (IDLE/ADDR/DATA), register offsets, ID_WTH = 4.
- One sub-module, mmu_rr_arb: combinational round-robin pick with registered pointer.
  - Ports: req, ptr, advance, gnt_idx, gnt_vld.

Test Plan:
- Req0 and req1 both post awlen=3 at once, rr_ptr=0: bursts are granted 0 then 1; m_awid = 0 then 1; 4 beats each; no interleaving of W.
- Req1 is continuously valid and req0 arrives mid-burst: req0 is granted immediately after req1's wlast, and req1 is not regranted before req0.
- MAX_OS=8 with B held off: the 9th AW is not granted; one B return leads to the 9th m_awvalid 2 cycles later.
- Same-cycle AW handshake and B (bid=1): os_cnt is unchanged; s_bvalid[1] = 1 only.
- m_bid = 3 with REQ_NUM = 2: m_bready = 1, err_cnt = 1, no s_bvalid.
- rst asserted mid-DATA burst: all valid/ready outputs 0 next edge; os_cnt = 0; a new burst completes normally after release.
